// File: rtl/ltmr_scrub_pkg.sv
// Shared types and helpers for the LTMR SEU scrubber.
package ltmr_scrub_pkg;

    // Scrubber sequencing states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        CHECK = 3'd2,
        WRITE = 3'd3,
        NEXT  = 3'd4
    } scrub_state_e;

    // Replica indices into per-replica vectors.
    localparam int unsigned NUM_REP = 3;
    localparam int unsigned REP_A   = 0;
    localparam int unsigned REP_B   = 1;
    localparam int unsigned REP_C   = 2;

    // Widest word vote3 handles; callers zero-extend in and truncate out.
    localparam int unsigned VOTE_MAX_W = 64;

    // Bitwise two-out-of-three majority.
    function automatic logic [VOTE_MAX_W-1:0] vote3(
        input logic [VOTE_MAX_W-1:0] a,
        input logic [VOTE_MAX_W-1:0] b,
        input logic [VOTE_MAX_W-1:0] c
    );
        return (a & b) | (b & c) | (c & a);
    endfunction

endpackage

// File: rtl/ltmr_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module ltmr_sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             CP,
    input  logic             CDN,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear first, otherwise increment unless already at full scale.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge CP or negedge CDN) begin
        if (!CDN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/ltmr_seu_scrubber.sv
// Periodic scrubber for a triplicated register array: read, vote, write back, count upsets.
module ltmr_seu_scrubber
    import ltmr_scrub_pkg::*;
#(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned AW           = $clog2(DEPTH),
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned SCRUB_PERIOD = 1024
) (
    input  logic             CP,
    input  logic             CDN,
    input  logic             start_i,
    input  logic             clr_cnt_i,
    output logic [AW-1:0]    rd_addr_o,
    output logic             rd_en_o,
    input  logic [WIDTH-1:0] rd_a_i,
    input  logic [WIDTH-1:0] rd_b_i,
    input  logic [WIDTH-1:0] rd_c_i,
    output logic             wr_en_o,
    output logic [AW-1:0]    wr_addr_o,
    output logic [WIDTH-1:0] wr_data_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] err_cnt_a_o,
    output logic [CNT_W-1:0] err_cnt_b_o,
    output logic [CNT_W-1:0] err_cnt_c_o,
    output logic             err_sticky_o
);

    localparam int unsigned    TW         = (SCRUB_PERIOD > 1) ? $clog2(SCRUB_PERIOD) : 1;
    localparam logic [TW-1:0]  TIMER_LAST = TW'(SCRUB_PERIOD - 1);
    localparam logic [AW-1:0]  ADDR_LAST  = AW'(DEPTH - 1);

    scrub_state_e       state_q;
    logic [AW-1:0]      addr_q;
    logic [TW-1:0]      timer_q;
    logic               rd_en_q;
    logic               wr_en_q;
    logic [AW-1:0]      wr_addr_q;
    logic [WIDTH-1:0]   wr_data_q;
    logic               busy_q;
    logic               sticky_q;

    logic [WIDTH-1:0]   vote;
    logic [NUM_REP-1:0] rep_err;
    logic               mismatch;

    // Majority of the replica words returned by the previous read.
    assign vote = WIDTH'(vote3(VOTE_MAX_W'(rd_a_i), VOTE_MAX_W'(rd_b_i), VOTE_MAX_W'(rd_c_i)));

    // A replica is charged with an upset only while its word is being checked.
    assign rep_err[REP_A] = (state_q == CHECK) && (rd_a_i != vote);
    assign rep_err[REP_B] = (state_q == CHECK) && (rd_b_i != vote);
    assign rep_err[REP_C] = (state_q == CHECK) && (rd_c_i != vote);
    assign mismatch       = |rep_err;

    // Scrub sequencer with address walk, idle timer and registered strobes.
    always_ff @(posedge CP or negedge CDN) begin
        if (!CDN) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            timer_q   <= '0;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i || (timer_q == TIMER_LAST)) begin
                        state_q <= READ;
                        timer_q <= '0;
                        rd_en_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                READ: begin
                    state_q <= CHECK;
                end
                CHECK: begin
                    if (mismatch) begin
                        state_q   <= WRITE;
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= addr_q;
                        wr_data_q <= vote;
                    end else begin
                        state_q <= NEXT;
                    end
                end
                WRITE: begin
                    state_q <= NEXT;
                end
                NEXT: begin
                    if (addr_q == ADDR_LAST) begin
                        addr_q  <= '0;
                        timer_q <= '0;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        addr_q  <= addr_q + AW'(1);
                        state_q <= READ;
                        rd_en_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Sticky upset flag; clear beats a simultaneous mismatch.
    always_ff @(posedge CP or negedge CDN) begin
        if (!CDN) begin
            sticky_q <= 1'b0;
        end else if (clr_cnt_i) begin
            sticky_q <= 1'b0;
        end else if (mismatch) begin
            sticky_q <= 1'b1;
        end
    end

    ltmr_sat_counter #(.CNT_W(CNT_W)) u_cnt_a (
        .CP    (CP),
        .CDN   (CDN),
        .inc_i (rep_err[REP_A]),
        .clr_i (clr_cnt_i),
        .cnt_o (err_cnt_a_o)
    );

    ltmr_sat_counter #(.CNT_W(CNT_W)) u_cnt_b (
        .CP    (CP),
        .CDN   (CDN),
        .inc_i (rep_err[REP_B]),
        .clr_i (clr_cnt_i),
        .cnt_o (err_cnt_b_o)
    );

    ltmr_sat_counter #(.CNT_W(CNT_W)) u_cnt_c (
        .CP    (CP),
        .CDN   (CDN),
        .inc_i (rep_err[REP_C]),
        .clr_i (clr_cnt_i),
        .cnt_o (err_cnt_c_o)
    );

    assign rd_addr_o    = addr_q;
    assign rd_en_o      = rd_en_q;
    assign wr_en_o      = wr_en_q;
    assign wr_addr_o    = wr_addr_q;
    assign wr_data_o    = wr_data_q;
    assign busy_o       = busy_q;
    assign err_sticky_o = sticky_q;

endmodule

// File: tb/tb_ltmr_seu_scrubber.sv
// Randomised bench for ltmr_seu_scrubber against a pass-level reference model.
module tb_ltmr_seu_scrubber;

    localparam int unsigned WIDTH        = 8;
    localparam int unsigned DEPTH        = 16;
    localparam int unsigned AW           = 4;
    localparam int unsigned CNT_W        = 2;
    localparam int unsigned SCRUB_PERIOD = 1024;
    localparam int          CNT_MAX      = (1 << CNT_W) - 1;

    logic             CP;
    logic             CDN;
    logic             start_i;
    logic             clr_cnt_i;
    logic [AW-1:0]    rd_addr_o;
    logic             rd_en_o;
    logic [WIDTH-1:0] rd_a_i;
    logic [WIDTH-1:0] rd_b_i;
    logic [WIDTH-1:0] rd_c_i;
    logic             wr_en_o;
    logic [AW-1:0]    wr_addr_o;
    logic [WIDTH-1:0] wr_data_o;
    logic             busy_o;
    logic [CNT_W-1:0] err_cnt_a_o;
    logic [CNT_W-1:0] err_cnt_b_o;
    logic [CNT_W-1:0] err_cnt_c_o;
    logic             err_sticky_o;

    ltmr_seu_scrubber #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .CNT_W(CNT_W), .SCRUB_PERIOD(SCRUB_PERIOD)
    ) dut (
        .CP(CP), .CDN(CDN), .start_i(start_i), .clr_cnt_i(clr_cnt_i),
        .rd_addr_o(rd_addr_o), .rd_en_o(rd_en_o),
        .rd_a_i(rd_a_i), .rd_b_i(rd_b_i), .rd_c_i(rd_c_i),
        .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
        .busy_o(busy_o),
        .err_cnt_a_o(err_cnt_a_o), .err_cnt_b_o(err_cnt_b_o), .err_cnt_c_o(err_cnt_c_o),
        .err_sticky_o(err_sticky_o)
    );

    initial CP = 1'b0;
    always #5 CP = ~CP;

    // Triplicated array contents and reference state.
    logic [WIDTH-1:0] mem_a [DEPTH];
    logic [WIDTH-1:0] mem_b [DEPTH];
    logic [WIDTH-1:0] mem_c [DEPTH];
    int checks;
    int errors;
    int cnt_m [3];
    bit sticky_m;

    // One clock: array answers the strobes seen before the edge, then settle.
    task automatic tick();
        logic             re, we;
        logic [AW-1:0]    ra, wa;
        logic [WIDTH-1:0] wd;
        re = rd_en_o; ra = rd_addr_o;
        we = wr_en_o; wa = wr_addr_o; wd = wr_data_o;
        @(posedge CP);
        #1;
        if (re) begin
            rd_a_i = mem_a[ra]; rd_b_i = mem_b[ra]; rd_c_i = mem_c[ra];
        end
        if (we) begin
            mem_a[wa] = wd; mem_b[wa] = wd; mem_c[wa] = wd;
        end
    endtask

    // Per-bit majority by counting ones.
    function automatic logic [WIDTH-1:0] maj(input logic [WIDTH-1:0] a, b, c);
        logic [WIDTH-1:0] m;
        int ones;
        for (int i = 0; i < int'(WIDTH); i++) begin
            ones = int'(a[i]) + int'(b[i]) + int'(c[i]);
            m[i] = (ones >= 2);
        end
        return m;
    endfunction

    task automatic fill_clean();
        logic [WIDTH-1:0] v;
        for (int i = 0; i < int'(DEPTH); i++) begin
            v = WIDTH'($urandom);
            mem_a[i] = v; mem_b[i] = v; mem_c[i] = v;
        end
    endtask

    task automatic check_counters(input string name);
        checks++;
        if (err_cnt_a_o !== CNT_W'(cnt_m[0]) || err_cnt_b_o !== CNT_W'(cnt_m[1]) ||
            err_cnt_c_o !== CNT_W'(cnt_m[2]) || err_sticky_o !== sticky_m) begin
            errors++;
            $display("FAIL %s counters got a=%0d b=%0d c=%0d sticky=%0b want a=%0d b=%0d c=%0d sticky=%0b",
                     name, err_cnt_a_o, err_cnt_b_o, err_cnt_c_o, err_sticky_o,
                     cnt_m[0], cnt_m[1], cnt_m[2], sticky_m);
        end
    endtask

    task automatic clear_counters();
        clr_cnt_i = 1'b1;
        tick();
        clr_cnt_i = 1'b0;
        cnt_m = '{0, 0, 0};
        sticky_m = 1'b0;
        check_counters("clear");
    endtask

    // Run or observe one full pass and compare it with the model's prediction.
    task automatic do_pass(input string name, input bit via_start, input bit poke);
        int               exp_wa[$];
        logic [WIDTH-1:0] exp_wd[$];
        int               got_wa[$];
        logic [WIDTH-1:0] got_wd[$];
        int               exp_cyc, cyc, nrd;
        int               inc [3];
        bit               order_ok, overlap;
        logic [WIDTH-1:0] v;
        exp_cyc = 0;
        inc = '{0, 0, 0};
        for (int a = 0; a < int'(DEPTH); a++) begin
            v = maj(mem_a[a], mem_b[a], mem_c[a]);
            if (mem_a[a] != v) inc[0]++;
            if (mem_b[a] != v) inc[1]++;
            if (mem_c[a] != v) inc[2]++;
            if (mem_a[a] != v || mem_b[a] != v || mem_c[a] != v) begin
                exp_wa.push_back(a);
                exp_wd.push_back(v);
                exp_cyc += 4;
            end else begin
                exp_cyc += 3;
            end
        end
        if (via_start) begin
            start_i = 1'b1;
            tick();
            start_i = 1'b0;
        end
        cyc = 0; nrd = 0; order_ok = 1'b1; overlap = 1'b0;
        while (busy_o === 1'b1 && cyc < 400) begin
            if (rd_en_o === 1'b1) begin
                if (rd_addr_o !== AW'(nrd)) order_ok = 1'b0;
                nrd++;
            end
            if (wr_en_o === 1'b1) begin
                got_wa.push_back(int'(wr_addr_o));
                got_wd.push_back(wr_data_o);
            end
            if (rd_en_o === 1'b1 && wr_en_o === 1'b1) overlap = 1'b1;
            start_i = poke;
            tick();
            cyc++;
        end
        start_i = 1'b0;
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < inc[r]; k++) if (cnt_m[r] < CNT_MAX) cnt_m[r]++;
        end
        if (exp_wa.size() > 0) sticky_m = 1'b1;

        checks++;
        if (cyc !== exp_cyc) begin
            errors++;
            $display("FAIL %s busy_cycles got %0d want %0d", name, cyc, exp_cyc);
        end
        checks++;
        if (nrd !== int'(DEPTH) || !order_ok) begin
            errors++;
            $display("FAIL %s reads got %0d in_order=%0b want %0d in_order=1", name, nrd, order_ok, DEPTH);
        end
        checks++;
        if (overlap) begin
            errors++;
            $display("FAIL %s rd_wr_overlap got 1 want 0", name);
        end
        checks++;
        if (got_wa.size() !== exp_wa.size()) begin
            errors++;
            $display("FAIL %s write_count got %0d want %0d", name, got_wa.size(), exp_wa.size());
        end
        for (int i = 0; i < exp_wa.size() && i < got_wa.size(); i++) begin
            checks++;
            if (got_wa[i] !== exp_wa[i] || got_wd[i] !== exp_wd[i]) begin
                errors++;
                $display("FAIL %s write%0d got addr=%0d data=%h want addr=%0d data=%h",
                         name, i, got_wa[i], got_wd[i], exp_wa[i], exp_wd[i]);
            end
        end
        check_counters(name);
    endtask

    task automatic test_reset();
        int n;
        CDN = 1'b0; start_i = 1'b0; clr_cnt_i = 1'b0;
        rd_a_i = '0; rd_b_i = '0; rd_c_i = '0;
        cnt_m = '{0, 0, 0}; sticky_m = 1'b0;
        fill_clean();
        repeat (3) @(posedge CP);
        #1;
        checks++;
        if ({rd_en_o, wr_en_o, busy_o, err_sticky_o, rd_addr_o, wr_addr_o, wr_data_o,
             err_cnt_a_o, err_cnt_b_o, err_cnt_c_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got nonzero want all 0");
        end
        CDN = 1'b1;
        n = 0;
        while (rd_en_o !== 1'b1 && n < 1200) begin
            tick();
            n++;
        end
        checks++;
        if (n !== int'(SCRUB_PERIOD)) begin
            errors++;
            $display("FAIL timer_first_read got %0d cycles want %0d", n, SCRUB_PERIOD);
        end
        do_pass("idle_pass", 1'b0, 1'b0);
    endtask

    task automatic test_single_upset();
        clear_counters();
        fill_clean();
        mem_a[5] = 8'h5A; mem_b[5] = 8'h5B; mem_c[5] = 8'h5A;
        do_pass("single_upset", 1'b1, 1'b0);
    endtask

    task automatic test_double_split();
        clear_counters();
        fill_clean();
        mem_a[0] = 8'h01; mem_b[0] = 8'h02; mem_c[0] = 8'h00;
        do_pass("double_split", 1'b1, 1'b0);
    endtask

    task automatic test_random();
        int a, r;
        logic [WIDTH-1:0] m;
        clear_counters();
        for (int p = 0; p < 5; p++) begin
            for (int k = 0; k < 3; k++) begin
                a = $urandom_range(0, DEPTH - 1);
                r = $urandom_range(0, 3);
                m = WIDTH'($urandom_range(1, 255));
                case (r)
                    0: mem_a[a] = mem_a[a] ^ m;
                    1: mem_b[a] = mem_b[a] ^ m;
                    2: mem_c[a] = mem_c[a] ^ m;
                    default: begin
                        mem_a[a] = mem_a[a] ^ (m & 8'h0F);
                        mem_c[a] = mem_c[a] ^ (m & 8'hF0);
                    end
                endcase
            end
            do_pass($sformatf("random%0d", p), 1'b1, 1'b0);
        end
    endtask

    task automatic test_saturation();
        int n;
        clear_counters();
        fill_clean();
        for (int p = 0; p < 4; p++) begin
            mem_c[3] = mem_a[3] ^ 8'h10;
            do_pass($sformatf("sat%0d", p), 1'b1, 1'b0);
        end
        mem_c[3] = mem_a[3] ^ 8'h04;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        n = 0;
        while (!(rd_en_o === 1'b1 && rd_addr_o === AW'(3)) && n < 50) begin
            tick();
            n++;
        end
        tick();
        clr_cnt_i = 1'b1;
        tick();
        clr_cnt_i = 1'b0;
        cnt_m = '{0, 0, 0};
        sticky_m = 1'b0;
        check_counters("clear_vs_inc");
        n = 0;
        while (busy_o === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 100 || mem_c[3] !== mem_a[3]) begin
            errors++;
            $display("FAIL clear_pass_end got busy_cycles=%0d c3=%h want <100 c3=%h", n, mem_c[3], mem_a[3]);
        end
        check_counters("after_clear_pass");
    endtask

    task automatic test_start_busy();
        int extra;
        fill_clean();
        mem_b[9] = mem_b[9] ^ 8'h21;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        checks++;
        if (busy_o !== 1'b1 || rd_en_o !== 1'b1 || rd_addr_o !== AW'(0)) begin
            errors++;
            $display("FAIL start_idle got busy=%0b rd_en=%0b addr=%0d want 1 1 0", busy_o, rd_en_o, rd_addr_o);
        end
        do_pass("start_while_busy", 1'b0, 1'b1);
        extra = 0;
        repeat (10) begin
            tick();
            if (busy_o !== 1'b0) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL start_not_queued got %0d busy cycles want 0", extra);
        end
    endtask

    task automatic test_reset_mid_pass();
        int n;
        clear_counters();
        fill_clean();
        mem_b[7] = mem_b[7] ^ 8'h80;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        n = 0;
        while (!(wr_en_o === 1'b1 && wr_addr_o === AW'(7)) && n < 60) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 60) begin
            errors++;
            $display("FAIL reach_write7 got timeout want write at addr 7");
        end
        CDN = 1'b0;
        #1;
        checks++;
        if ({rd_en_o, wr_en_o, busy_o, err_sticky_o, rd_addr_o, wr_addr_o, wr_data_o,
             err_cnt_a_o, err_cnt_b_o, err_cnt_c_o} !== '0) begin
            errors++;
            $display("FAIL midpass_reset_outputs got nonzero want all 0");
        end
        @(posedge CP);
        #1;
        CDN = 1'b1;
        cnt_m = '{0, 0, 0};
        sticky_m = 1'b0;
        repeat (3) tick();
        checks++;
        if (busy_o !== 1'b0 || mem_b[7] === mem_a[7]) begin
            errors++;
            $display("FAIL no_partial_write got busy=%0b b7=%h want busy=0 b7!=%h", busy_o, mem_b[7], mem_a[7]);
        end
        do_pass("after_reset", 1'b1, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_upset();
        test_double_split();
        test_random();
        test_saturation();
        test_start_busy();
        test_reset_mid_pass();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
